// File: rtl/riscv_int_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package riscv_int_pkg;

  localparam int          INT_LINES      = 32;
  localparam logic [31:0] MCAUSE_INT_BIT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    BUSY = 2'd2,
    ACK  = 2'd3
  } int_state_t;

endpackage

// File: rtl/riscv_int_prio.sv
// Fixed-priority encoder: reports the lowest set bit of the request vector.
module riscv_int_prio
  import riscv_int_pkg::*;
(
  input  logic [INT_LINES-1:0] req_i,
  output logic [4:0]           idx_o,
  output logic                 valid_o
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    idx_o   = 5'd0;
    valid_o = 1'b0;
    for (int i = INT_LINES - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 5'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_int_ctrl.sv
// Machine-mode interrupt controller: pending capture, priority select, and
// the IDLE/TAKE/BUSY/ACK entry handshake with the core.
module riscv_int_ctrl
  import riscv_int_pkg::*;
#(
  parameter logic [31:0] EDGE_MASK = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] int_req_i,
  input  logic [31:0] mie_i,
  input  logic        stall_i,
  input  logic        INT_RST,
  output logic        IC_INT,
  output logic [31:0] mcause_o,
  output logic [31:0] int_fin_o,
  output logic        busy_o
);

  int_state_t  state_q, state_d;
  logic [31:0] req_q, req_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] mcause_q, mcause_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] set_vec, clr_vec, pend, elig;
  logic [4:0]  prio_idx;
  logic        prio_valid;

  assign set_vec = EDGE_MASK & int_req_i & ~req_q;
  assign clr_vec = (state_q == ACK) ? (32'd1 << idx_q) : 32'd0;
  // Edge lines come from the latched pending bits; level lines pass straight through.
  assign pend    = (pend_q & EDGE_MASK) | (int_req_i & ~EDGE_MASK);
  assign elig    = pend & mie_i;

  riscv_int_prio u_prio (
    .req_i   (elig),
    .idx_o   (prio_idx),
    .valid_o (prio_valid)
  );

  always_comb begin
    req_d    = int_req_i;
    pend_d   = ((pend_q & ~clr_vec) | set_vec) & EDGE_MASK;
    state_d  = state_q;
    idx_d    = idx_q;
    mcause_d = mcause_q;
    case (state_q)
      IDLE: begin
        if (prio_valid && !stall_i) begin
          idx_d    = prio_idx;
          mcause_d = MCAUSE_INT_BIT | {27'd0, prio_idx};
          state_d  = TAKE;
        end
      end
      TAKE:    state_d = BUSY;
      BUSY:    if (INT_RST) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '1;
      pend_q   <= '0;
      idx_q    <= '0;
      mcause_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      mcause_q <= mcause_d;
    end
  end

  assign IC_INT    = (state_q == TAKE);
  assign busy_o    = (state_q != IDLE);
  assign int_fin_o = clr_vec;
  assign mcause_o  = mcause_q;

endmodule

// File: tb/tb_riscv_int_ctrl.sv
// Scoreboard bench for riscv_int_ctrl: stimulus queues expected entries and
// acknowledges, a negedge monitor pops and compares whenever the DUT emits one.
module tb_riscv_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] int_req_i;
  logic [31:0] mie_i;
  logic        stall_i;
  logic        INT_RST;
  logic        IC_INT;
  logic [31:0] mcause_o;
  logic [31:0] int_fin_o;
  logic        busy_o;

  riscv_int_ctrl #(.EDGE_MASK(32'h0000_0020)) dut (
    .clk       (clk),
    .rst       (rst),
    .int_req_i (int_req_i),
    .mie_i     (mie_i),
    .stall_i   (stall_i),
    .INT_RST   (INT_RST),
    .IC_INT    (IC_INT),
    .mcause_o  (mcause_o),
    .int_fin_o (int_fin_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_fin;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_total  = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ent_cyc  = -1;
  int   fin_cyc  = -1;
  int   n, m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_ent(input int idx);
    sb.push_back('{is_fin: 1'b0, val: 32'h8000_0000 | 32'(idx)});
  endtask

  task automatic push_fin(input logic [31:0] onehot);
    sb.push_back('{is_fin: 1'b1, val: onehot});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (IC_INT) begin
        ent_cyc = cyc;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_entry: got mcause %0h expected no entry", mcause_o);
        end else begin
          e_mon = sb.pop_front();
          if (!e_mon.is_fin && mcause_o === e_mon.val) n_pass++;
          else $display("FAIL entry_mcause: got entry mcause %0h expected %s %0h",
                        mcause_o, e_mon.is_fin ? "ack" : "entry", e_mon.val);
        end
        $display("cycle %0d: entry mcause=%08h", cyc, mcause_o);
      end
      if (int_fin_o != 32'd0) begin
        fin_cyc = cyc;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_ack: got int_fin %0h expected no ack", int_fin_o);
        end else begin
          e_mon = sb.pop_front();
          if (e_mon.is_fin && int_fin_o === e_mon.val) n_pass++;
          else $display("FAIL ack_onehot: got ack %0h expected %s %0h",
                        int_fin_o, e_mon.is_fin ? "ack" : "entry", e_mon.val);
        end
        $display("cycle %0d: ack int_fin=%08h", cyc, int_fin_o);
      end
    end
  end

  initial begin
    rst = 1'b1; int_req_i = '0; mie_i = '0; stall_i = 1'b0; INT_RST = 1'b0;
    step(2);
    chk("rst_ic_int", 32'(IC_INT), 0);
    chk("rst_int_fin", int_fin_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_mcause", mcause_o, 0);
    rst = 1'b0;
    step(1);

    // Level line 3 held high; released once its acknowledge appears.
    mie_i = 32'h8; int_req_i = 32'h8; n = cyc; push_ent(3);
    step(2);
    chk("t1_entry_cycle", ent_cyc, n + 1);
    chk("t1_busy", 32'(busy_o), 1);
    step(4);
    push_fin(32'h8); INT_RST = 1'b1; m = cyc;
    step(1);
    INT_RST = 1'b0; int_req_i = '0;
    step(2);
    chk("t1_ack_cycle", fin_cyc, m + 1);
    step(4);

    // Lines 2 and 7 together: 2 first, 7 re-enters two cycles after the ack.
    mie_i = 32'h84; int_req_i = 32'h84; push_ent(2);
    step(4);
    push_fin(32'h4); INT_RST = 1'b1; m = cyc;
    step(1);
    INT_RST = 1'b0; int_req_i = 32'h80; push_ent(7);
    step(3);
    chk("t2_ack_cycle", fin_cyc, m + 1);
    chk("t2_reentry_cycle", ent_cyc, m + 3);
    step(2);
    push_fin(32'h80); INT_RST = 1'b1;
    step(1);
    INT_RST = 1'b0; int_req_i = '0;
    step(4);

    // Edge line 5 pulsed while masked, then enabled later.
    mie_i = '0; int_req_i = 32'h20;
    step(1);
    int_req_i = '0;
    step(5);
    chk("t3_masked_idle", 32'(busy_o), 0);
    mie_i = 32'h20; n = cyc; push_ent(5);
    step(2);
    chk("t3_entry_cycle", ent_cyc, n + 1);
    push_fin(32'h20); INT_RST = 1'b1;
    step(1);
    INT_RST = 1'b0;
    step(5);
    chk("t3_pend_cleared", 32'(busy_o), 0);
    mie_i = '0;

    // Stall holds off an eligible line 0 for four cycles.
    stall_i = 1'b1; mie_i = 32'h1; int_req_i = 32'h1;
    step(4);
    chk("t4_stalled_idle", 32'(busy_o), 0);
    push_ent(0); stall_i = 1'b0; n = cyc;
    step(2);
    chk("t4_entry_cycle", ent_cyc, n + 1);
    push_fin(32'h1); INT_RST = 1'b1;
    step(1);
    INT_RST = 1'b0; int_req_i = '0; mie_i = '0;
    step(3);

    // INT_RST in IDLE and in TAKE is ignored; a new edge colliding with ACK survives.
    INT_RST = 1'b1;
    step(1);
    INT_RST = 1'b0;
    step(3);
    chk("t5_idle_rst_ignored", 32'(busy_o), 0);
    mie_i = 32'h20; int_req_i = 32'h20; n = cyc; push_ent(5);
    step(2);
    INT_RST = 1'b1;
    step(1);
    INT_RST = 1'b0; int_req_i = '0;
    chk("t5_entry_cycle", ent_cyc, n + 2);
    chk("t5_take_rst_ignored", 32'(busy_o), 1);
    step(1);
    push_fin(32'h20); INT_RST = 1'b1;
    step(1);
    INT_RST = 1'b0; int_req_i = 32'h20; push_ent(5);
    step(3);
    chk("t5_ack_cycle", fin_cyc, n + 5);
    chk("t5_relatch_entry_cycle", ent_cyc, n + 7);

    // Reset mid-service with line 5 still held high.
    rst = 1'b1;
    step(1);
    chk("t6_ic_int", 32'(IC_INT), 0);
    chk("t6_int_fin", int_fin_o, 0);
    chk("t6_busy", 32'(busy_o), 0);
    chk("t6_mcause", mcause_o, 0);
    step(1);
    rst = 1'b0;
    step(6);
    chk("t6_held_line_not_pending", 32'(busy_o), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_int_ctrl.md
# riscv_int_ctrl

Machine-mode interrupt controller for the RISC-V core; it is the interrupt-side counterpart of the CSR file. It collects 32 external interrupt lines and masks them with `mie` from the CSR file. It selects the highest-priority pending line, drives the one-cycle `IC_INT` entry pulse together with `mcause`, then holds off further entries until the core executes `mret`. After `mret` it acknowledges the serviced source.

## Interface
- `EDGE_MASK`, default `32'h0000_0000`: bit i = 1 makes line i edge-triggered (rising edge latched into pending); bit i = 0 makes it level-triggered.
- `clk  in  1`: core clock; all state updates on its rising edge.
- `rst  in  1`: reset; synchronous, active-high.
- `int_req_i  in  32`: external interrupt requests, one per line.
- `mie_i  in  32`: enable mask from the CSR file.
- `stall_i  in  1`: core stalled; interrupt entry is deferred while high.
- `INT_RST  in  1`: one-cycle pulse when the core executes `mret`.
- `IC_INT  out  1`: one-cycle pulse. The CSR file saves PC→mepc and `mcause_o`→mcause; the core redirects to mtvec.
- `mcause_o  out  32`: cause of the serviced interrupt, equal to `32'h8000_0000 | idx`.
- `int_fin_o  out  32`: one-hot acknowledge pulse to the serviced source.
- `busy_o  out  1`: high from TAKE through ACK.

## Operation
- Edge lines (`EDGE_MASK[i]=1`):
  - `req_q` is registered `int_req_i`; its reset value is all-ones, so a line held high through reset does not count as an edge.
  - `pend[i]` is set when `int_req_i[i] & ~req_q[i]`.
  - `pend[i]` is cleared in ACK when `i == idx`.
  - If set and clear occur in the same cycle, set wins.
- Level lines: `pend[i] = int_req_i[i]`, purely combinational. The source must hold its request until it sees `int_fin_o[i]`.
- Eligibility: `elig = pend & mie_i`. Fixed priority, lowest index wins.
- FSM states, all transitions registered:
  - IDLE: if `elig != 0 && !stall_i`, latch `idx`, load `mcause_o`, go to TAKE. If `stall_i` is high, stay in IDLE.
  - TAKE: `IC_INT = 1` for exactly this one cycle. Go to BUSY unconditionally.
  - BUSY: wait. On `INT_RST`, go to ACK. No nesting; new requests accumulate in pending.
  - ACK: `int_fin_o = 1 << idx` for one cycle, clear the edge pending bit. Go to IDLE.
- `INT_RST` is ignored in every state other than BUSY.
- `mie_i` changes while busy do not affect the current `idx`.
- `mcause_o` holds its value from TAKE until the next entry; the CSR file samples it only while `IC_INT` is high.
- Reset, including mid-operation:
  - FSM → IDLE.
  - `pend` cleared, `req_q` set to all-ones.
  - `IC_INT = 0`, `int_fin_o = 0`, `busy_o = 0`, `mcause_o = 0`.
  - An in-flight service is dropped without acknowledge.

## Timing
- Level line asserted during cycle 0 with mie set and no stall:
  - Edge 1: IDLE→TAKE.
  - `IC_INT` high during cycle 1.
- Edge line rising in cycle 0:
  - Edge 1: pend set.
  - Edge 2: IDLE→TAKE.
  - `IC_INT` high during cycle 2.
- `INT_RST` sampled high in BUSY at edge k: ACK during cycle k, `int_fin_o` valid in that cycle.
- Earliest re-entry: the IDLE decision is made at edge k+1 (a level source still asserted is taken again), with `IC_INT` high during cycle k+2. The minimum entry-to-entry spacing is 4 cycles.
- Outputs are registered or Moore-decoded from state; there are no combinational paths from inputs to `IC_INT` or `int_fin_o`.

## Structure
- Package `riscv_int_pkg`:
  - State enum `int_state_t {IDLE, TAKE, BUSY, ACK}`.
  - `MCAUSE_INT_BIT = 32'h8000_0000`.
  - Line count constant `INT_LINES = 32`.
- Sub-module `riscv_int_prio`: 32-bit request vector in; 5-bit lowest-set index plus a valid flag out; purely combinational.
- Top-level contents: edge detect, pending register, FSM, output registers.

## Test plan
- Level line 3, `mie_i = 32'h8`, `int_req_i[3]` held high:
  - `IC_INT` pulses one cycle later with `mcause_o = 32'h8000_0003`.
  - `INT_RST` 5 cycles later → `int_fin_o = 32'h8` for one cycle.
  - Releasing the request then → no further entry.
- Lines 7 and 2 requested in the same cycle, both enabled: line 2 is serviced first (`mcause_o = 32'h8000_0002`). After its ack and `INT_RST`, line 7 is serviced.
- Edge line 5 (`EDGE_MASK = 32'h20`) with `mie_i[5] = 0`, one-cycle pulse on the line:
  - No entry.
  - Later set `mie_i[5] = 1` → entry with `mcause_o = 32'h8000_0005`; pending clears at ACK.
- `stall_i` held high for 4 cycles while line 0 is eligible: `IC_INT` stays low. It pulses in the cycle after `stall_i` falls.
- `INT_RST` pulsed in IDLE and in TAKE: ignored, no `int_fin_o`. A second rising edge on the serviced edge line during BUSY is re-latched and re-enters after ACK.
- `rst` asserted while BUSY: all outputs read 0 next cycle, no `int_fin_o`. An edge line held high through reset is not treated as pending.
